banked_burst_memory: RTL
========================

BANKED_BURST_MEMORY -- requirements
Module: banked_burst_memory

Interface
REQ-001 SHALL have parameter DELAY_MEM, default 10, cycles from request to first beat on an open-page miss (>=1).
REQ-002 SHALL have parameter DELAY_PAGE_HIT, default 3, cycles from request to first beat on an open-page hit (1..DELAY_MEM).
REQ-003 SHALL have parameter BURST_LEN, default 4, beats per line.
REQ-004 SHALL have parameter LINE_WIDTH, default 256, line width in bits; BEAT_W = LINE_WIDTH/BURST_LEN.
REQ-005 SHALL have parameter PAGE_SIZE, default 2048, page size in bytes (power of two).
REQ-006 SHALL have parameter NUM_BANKS, default 4, independent open-page trackers (power of two).
REQ-007 SHALL have parameter DEPTH_LINES, default 1024, storage depth in lines (power of two).
REQ-008 SHALL have ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-009 SHALL have ports: mem_read in 1 and mem_write in 1, request levels held until the burst completes.
REQ-010 SHALL have ports: mem_address in 32, byte address (low log2(LINE_WIDTH/8) bits ignored); mem_wdata in BEAT_W, write beat; mem_byte_enable in BEAT_W/8, per-byte write strobe.
REQ-011 SHALL have ports: mem_rdata out BEAT_W, read beat; mem_resp out 1, beat valid; pm_error out 1, sticky protocol error.

Function
REQ-012 SHALL sample requests only in IDLE; FSM states IDLE -> WAIT -> BURST -> IDLE.
REQ-013 SHALL compute bank = (addr/PAGE_SIZE) mod NUM_BANKS and row = addr/(PAGE_SIZE*NUM_BANKS); hit when bank's open row is valid and equal.
REQ-014 SHALL load delay = hit ? DELAY_PAGE_HIT : DELAY_MEM on acceptance and record the row as open for that bank.
REQ-015 SHALL assert mem_resp on the delay-th edge after acceptance for exactly BURST_LEN consecutive cycles, then return to IDLE.
REQ-016 SHALL, on a read, drive mem_rdata = line bits [BEAT_W*i +: BEAT_W] during beat i (i = 0..BURST_LEN-1); mem_rdata is 0 outside beats.
REQ-017 SHALL, on a write, commit mem_wdata bytes whose mem_byte_enable bit is 1 into beat i of the line at the edge ending beat i.
REQ-018 SHALL index storage by line address modulo DEPTH_LINES (wrap-around, no out-of-range error).
REQ-019 SHALL, in WAIT or BURST, on request deassert, opposite request assert, or address change, set pm_error, drop mem_resp next cycle, abort remaining beats (committed beats kept), go IDLE.
REQ-020 SHALL, on mem_read and mem_write both high in IDLE, set pm_error and accept nothing.
REQ-021 SHALL accept a new request no earlier than the cycle after the last beat (one idle cycle between bursts).
REQ-022 SHALL hold pm_error at 1 until rst; an error does not block subsequent legal requests.

Reset
REQ-023 SHALL, when rst is high at an edge, force IDLE, mem_resp=0, mem_rdata=0, pm_error=0, and invalidate all open rows, including mid-burst.
REQ-024 SHALL retain storage contents across rst; no beat of an interrupted write commits after the reset edge.

Structure
REQ-025 SHALL place state enum and derived widths (BEAT_W, offset/bank/row bit counts) in package banked_burst_memory_pkg.
REQ-026 SHALL implement open-row tracking as sub-module open_page_table (lookup, update, clear ports).

Verification
REQ-027 Cold read 0x0000_0040 -> mem_resp high 10 cycles after acceptance for 4 cycles, beats = line 2 bits [63:0],[127:64],[191:128],[255:192].
REQ-028 Second read 0x0000_0080 same page -> first beat after 3 cycles; read to 0x0000_2040 (bank 0, row 1) -> 10 cycles.
REQ-029 Write line 0x100 with byte_enable 0x0F on beat 1, then read -> beat 1 low 4 bytes new, high 4 old; other beats unchanged.
REQ-030 Drop mem_read in cycle 2 of BURST -> pm_error=1 next edge, mem_resp=0, next legal read completes normally with pm_error still 1.
REQ-031 Read+write simultaneous in IDLE -> pm_error=1, no mem_resp; rst mid-write after beat 1 -> only beats 0-1 committed, next read to same page takes 10 cycles.
REQ-032 Address 0x0000_0000 and DEPTH_LINES*32 bytes -> same line (wrap-around) on readback.

Source files
------------

// File: rtl/banked_burst_memory_pkg.sv
// Shared types and width helpers for the banked burst memory model.
// Widths are derived from the top-level parameters through these functions.
package banked_burst_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    // Never returns zero so a one-entry dimension still gets a legal vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int beat_width(input int line_w, input int burst_len);
        return line_w / burst_len;
    endfunction

    function automatic int offset_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int page_bits(input int page_size);
        return $clog2(page_size);
    endfunction

    function automatic int bank_bits(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int row_bits(input int page_size, input int num_banks);
        return 32 - $clog2(page_size) - $clog2(num_banks);
    endfunction

endpackage

// File: rtl/banked_burst_memory_open_page_table.sv
// Per-bank open-row tracker: combinational lookup, single-entry update,
// and a synchronous clear that invalidates every bank.
module open_page_table
    import banked_burst_memory_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 19
) (
    input  logic                                clk,
    input  logic                                clear,
    input  logic [clog2_min1(NUM_BANKS)-1:0]    lookup_bank,
    input  logic [ROW_W-1:0]                    lookup_row,
    output logic                                lookup_hit,
    input  logic                                update_en,
    input  logic [clog2_min1(NUM_BANKS)-1:0]    update_bank,
    input  logic [ROW_W-1:0]                    update_row
);

    logic [NUM_BANKS-1:0] valid_q, valid_d;
    logic [ROW_W-1:0]     row_q [NUM_BANKS];
    logic [ROW_W-1:0]     row_d [NUM_BANKS];

    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        if (update_en) begin
            valid_d[update_bank] = 1'b1;
            row_d[update_bank]   = update_row;
        end
    end

    // Row values need no reset: they are ignored while their valid bit is low.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        row_q <= row_d;
    end

    assign lookup_hit = valid_q[lookup_bank] && (row_q[lookup_bank] == lookup_row);

endmodule

// File: rtl/banked_burst_memory.sv
// Line-granular burst memory with per-bank open-page latency modelling and
// a sticky protocol-error flag for malformed request sequences.
module banked_burst_memory
    import banked_burst_memory_pkg::*;
#(
    parameter int DELAY_MEM      = 10,
    parameter int DELAY_PAGE_HIT = 3,
    parameter int BURST_LEN      = 4,
    parameter int LINE_WIDTH     = 256,
    parameter int PAGE_SIZE      = 2048,
    parameter int NUM_BANKS      = 4,
    parameter int DEPTH_LINES    = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          mem_read,
    input  logic                                          mem_write,
    input  logic [31:0]                                   mem_address,
    input  logic [beat_width(LINE_WIDTH, BURST_LEN)-1:0]  mem_wdata,
    input  logic [beat_width(LINE_WIDTH, BURST_LEN)/8-1:0] mem_byte_enable,
    output logic [beat_width(LINE_WIDTH, BURST_LEN)-1:0]  mem_rdata,
    output logic                                          mem_resp,
    output logic                                          pm_error,
    output state_e                                        dbg_state
);

    localparam int BEAT_W     = beat_width(LINE_WIDTH, BURST_LEN);
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int OFF_W      = offset_bits(LINE_WIDTH);
    localparam int PAGE_W     = page_bits(PAGE_SIZE);
    localparam int BANK_W     = clog2_min1(NUM_BANKS);
    localparam int ROW_W      = row_bits(PAGE_SIZE, NUM_BANKS);
    localparam int LADDR_W    = 32 - OFF_W;
    localparam int IDX_W      = clog2_min1(DEPTH_LINES);
    localparam int CNT_W      = clog2_min1(DELAY_MEM + 1);
    localparam int BEAT_IDX_W = clog2_min1(BURST_LEN);
    localparam int BIT_IDX_W  = clog2_min1(LINE_WIDTH);

    localparam logic [CNT_W-1:0]      DLY_MEM_C = CNT_W'(DELAY_MEM);
    localparam logic [CNT_W-1:0]      DLY_HIT_C = CNT_W'(DELAY_PAGE_HIT);
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BURST_LEN - 1);

    // Handshake: a request level (mem_read xor mem_write) with a stable address
    // is sampled in IDLE; it must stay unchanged until the last mem_resp beat,
    // after which the master drops it or re-presents a fresh request.
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BEAT_IDX_W-1:0]  beat_q, beat_d;
    logic                   is_write_q, is_write_d;
    logic [LADDR_W-1:0]     laddr_q, laddr_d;
    logic                   pm_error_q, pm_error_d;

    logic [LINE_WIDTH-1:0]  mem_q [DEPTH_LINES];

    logic [LADDR_W-1:0]     req_laddr;
    logic [BANK_W-1:0]      req_bank;
    logic [ROW_W-1:0]       req_row;
    logic                   page_hit;
    logic                   upd_en;
    logic                   commit_en;
    logic                   req_broken;
    logic [IDX_W-1:0]       line_idx;
    logic [BIT_IDX_W-1:0]   beat_base;
    logic                   addr_unused;

    assign req_laddr   = mem_address[31:OFF_W];
    assign req_bank    = BANK_W'((mem_address >> PAGE_W) & 32'(NUM_BANKS - 1));
    assign req_row     = ROW_W'(mem_address >> (PAGE_W + bank_bits(NUM_BANKS)));
    assign addr_unused = ^mem_address[OFF_W-1:0];
    assign line_idx    = laddr_q[IDX_W-1:0];
    assign beat_base   = BIT_IDX_W'(int'(beat_q) * BEAT_W);

    assign req_broken = (is_write_q ? !(mem_write && !mem_read) : !(mem_read && !mem_write))
                        || (req_laddr != laddr_q);

    open_page_table #(
        .NUM_BANKS (NUM_BANKS),
        .ROW_W     (ROW_W)
    ) u_open_page_table (
        .clk         (clk),
        .clear       (rst),
        .lookup_bank (req_bank),
        .lookup_row  (req_row),
        .lookup_hit  (page_hit),
        .update_en   (upd_en),
        .update_bank (req_bank),
        .update_row  (req_row)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        is_write_d = is_write_q;
        laddr_d    = laddr_q;
        pm_error_d = pm_error_q;
        upd_en     = 1'b0;
        commit_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read && mem_write) begin
                    pm_error_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    is_write_d = mem_write;
                    laddr_d    = req_laddr;
                    cnt_d      = page_hit ? DLY_HIT_C : DLY_MEM_C;
                    upd_en     = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (req_broken) begin
                    pm_error_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    beat_d  = '0;
                    state_d = ST_BURST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BURST: begin
                // A broken request ends the burst without committing the current beat.
                if (req_broken) begin
                    pm_error_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    commit_en = is_write_q;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            is_write_q <= 1'b0;
            laddr_q    <= '0;
            pm_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            is_write_q <= is_write_d;
            laddr_q    <= laddr_d;
            pm_error_q <= pm_error_d;
        end
    end

    // Storage survives reset; only the in-flight beat is suppressed.
    always_ff @(posedge clk) begin
        if (commit_en && !rst) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                if (mem_byte_enable[b]) begin
                    mem_q[line_idx][beat_base + BIT_IDX_W'(b * 8) +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (state_q == ST_BURST && !is_write_q) begin
            mem_rdata = mem_q[line_idx][beat_base +: BEAT_W];
        end
    end

    assign mem_resp  = (state_q == ST_BURST);
    assign pm_error  = pm_error_q;
    assign dbg_state = state_q;

endmodule
